// File: rtl/jogo_desafio_memoria.sv
// -----------------------------------------------------------------------------
// jogo_desafio_memoria
// Simon-style memory game: controller FSM plus datapath for a 1 kHz board clock.
// Each round appends one item from a selectable 16-entry ROM, shows that item on
// the LEDs, and then waits for the player to repeat the whole sequence so far on
// four one-hot buttons. A wrong button or (optionally) silence loses; finishing
// the last round (8 or 16 rounds) wins.
//
// Optional feature macro: TIMEOUT_EN
//   defined   -> ESPERA runs a timer; T_TIMEOUT idle cycles end in FIM_TIMEOUT
//   undefined -> ESPERA waits indefinitely, timeout is tied low
//
// Parameters:
//   T_SHOW     cycles the new round's item stays lit on leds
//   T_TIMEOUT  idle cycles allowed in ESPERA before a timeout
//
// Ports:
//   clock                     system clock, rising edge
//   reset                     asynchronous reset, active-low
//   jogar                     start request (level), honoured in idle/end states
//   botoes[3:0]               player buttons, one-hot, 0000 = no press
//   nivel                     0 = 8 rounds, 1 = 16 rounds (latched at start)
//   memoria                   ROM select (latched at start)
//   leds[3:0]                 item during MOSTRA, otherwise echoes botoes
//   ganhou/perdeu/pronto      win / loss / any end state
//   timeout                   timeout end state
//   db_*                      debug comparison flags
//   display_*[6:0]            7-segment hex digits, active-low, bit0 = a
// -----------------------------------------------------------------------------
module jogo_desafio_memoria #(
    parameter int T_SHOW    = 1000,
    parameter int T_TIMEOUT = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] botoes,
    input  logic       nivel,
    input  logic       memoria,
    output logic [3:0] leds,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic       timeout,
    output logic       db_jogadaIgualMemoria,
    output logic       db_enderecoIgualSequencia,
    output logic       db_tem_jogada,
    output logic       db_fimS,
    output logic [6:0] display_sequencia,
    output logic [6:0] display_jogada,
    output logic [6:0] display_memoria,
    output logic [6:0] display_endereco,
    output logic [6:0] display_estado
);

    // One timer serves both the show window and the idle timeout, so it is
    // sized for the larger of the two.
    localparam int TMAX = (T_TIMEOUT > T_SHOW) ? T_TIMEOUT : T_SHOW;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0] SHOW_LAST = TW'(T_SHOW - 1);
`ifdef TIMEOUT_EN
    localparam logic [TW-1:0] TO_LAST = TW'(T_TIMEOUT - 1);
`endif

    // ROM contents packed with address 0 in the lowest nibble.
    localparam logic [63:0] ROM0 = 64'h4188_4422_1124_8421;
    localparam logic [63:0] ROM1 = 64'h2814_4182_8421_1248;

    // State codes are what display_estado shows, so they are fixed values.
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        MOSTRA      = 4'h2,
        ESPERA      = 4'h3,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROX_JOG    = 4'h6,
        PROX_SEQ    = 4'h7,
        FIM_ACERTOU = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERROU   = 4'hE
    } estado_t;

    estado_t       estado;
    estado_t       proximo;
    logic [3:0]    sequencia;
    logic [3:0]    endereco;
    logic [3:0]    jogada;
    logic [3:0]    botoes_q;
    logic [TW-1:0] timer;
    logic          nivel_reg;
    logic          memoria_reg;
    logic          jogada_borda;
    logic          jogada_correta;
    logic          fim_s;
    logic [3:0]    item_mostra;
    logic [3:0]    item_endereco;

    function automatic logic [3:0] rom_item(input logic sel, input logic [3:0] addr);
        logic [5:0] base;
        base = {addr, 2'b00};
        return sel ? ROM1[base +: 4] : ROM0[base +: 4];
    endfunction

    // Active-low segments, bit0 = a ... bit6 = g; "b" and "d" are lower-case.
    function automatic logic [6:0] hex7(input logic [3:0] digito);
        logic [6:0] seg;
        case (digito)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // A play is the rising edge of "any button pressed"; the previous-cycle
    // buttons are kept regardless of state so a button held across states is
    // never counted twice.
    assign jogada_borda   = (|botoes) && !(|botoes_q);
    assign item_mostra    = rom_item(memoria_reg, sequencia);
    assign item_endereco  = rom_item(memoria_reg, endereco);
    assign jogada_correta = (jogada == item_endereco);
    assign fim_s          = (sequencia == (nivel_reg ? 4'd15 : 4'd7));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:  if (jogar) proximo = PREPARA;
            PREPARA:  proximo = MOSTRA;
            MOSTRA:   if (timer == SHOW_LAST) proximo = ESPERA;
            ESPERA: begin
                // A press landing on the last idle cycle still counts.
                if (jogada_borda) proximo = REGISTRA;
`ifdef TIMEOUT_EN
                else if (timer == TO_LAST) proximo = FIM_TIMEOUT;
`endif
            end
            REGISTRA: proximo = COMPARA;
            COMPARA: begin
                if (!jogada_correta)            proximo = FIM_ERROU;
                else if (endereco == sequencia) proximo = PROX_SEQ;
                else                            proximo = PROX_JOG;
            end
            PROX_JOG: proximo = ESPERA;
            PROX_SEQ: proximo = fim_s ? FIM_ACERTOU : MOSTRA;
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: if (jogar) proximo = PREPARA;
            default:  proximo = INICIAL;
        endcase
    end

    // Datapath registers are steered by the current state; the play register
    // loads the buttons as they were on the edge cycle, so even a one-cycle
    // press is captured correctly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sequencia   <= '0;
            endereco    <= '0;
            jogada      <= '0;
            botoes_q    <= '0;
            timer       <= '0;
            nivel_reg   <= 1'b0;
            memoria_reg <= 1'b0;
        end else begin
            botoes_q <= botoes;
            case (estado)
                PREPARA: begin
                    sequencia   <= '0;
                    endereco    <= '0;
                    timer       <= '0;
                    nivel_reg   <= nivel;
                    memoria_reg <= memoria;
                end
                MOSTRA: begin
                    if (timer == SHOW_LAST) begin
                        timer    <= '0;
                        endereco <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ESPERA: begin
                    if (jogada_borda) timer <= '0;
`ifdef TIMEOUT_EN
                    else timer <= timer + 1'b1;
`endif
                end
                REGISTRA: jogada <= botoes_q;
                PROX_JOG: endereco <= endereco + 4'd1;
                PROX_SEQ: begin
                    if (!fim_s) begin
                        sequencia <= sequencia + 4'd1;
                        timer     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign leds    = (estado == MOSTRA) ? item_mostra : botoes;
    assign ganhou  = (estado == FIM_ACERTOU);
    assign perdeu  = (estado == FIM_ERROU) || (estado == FIM_TIMEOUT);
    assign pronto  = (estado == FIM_ACERTOU) || (estado == FIM_ERROU) || (estado == FIM_TIMEOUT);
`ifdef TIMEOUT_EN
    assign timeout = (estado == FIM_TIMEOUT);
`else
    assign timeout = 1'b0;
`endif

    assign db_jogadaIgualMemoria     = jogada_correta;
    assign db_enderecoIgualSequencia = (endereco == sequencia);
    assign db_tem_jogada             = |botoes;
    assign db_fimS                   = fim_s;

    assign display_sequencia = hex7(sequencia);
    assign display_jogada    = hex7(jogada);
    assign display_memoria   = hex7(item_endereco);
    assign display_endereco  = hex7(endereco);
    assign display_estado    = hex7(estado);

endmodule

// File: tb/tb_jogo_desafio_memoria.sv
// -----------------------------------------------------------------------------
// tb_jogo_desafio_memoria
// Self-checking bench for jogo_desafio_memoria: a table of whole-game scenarios
// with hand-derived outcomes, randomized games predicted by a game-rule model,
// plus hand-written sequences for reset, restart, show length and timeout.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jogo_desafio_memoria;

    localparam int T_SHOW    = 1000;
    localparam int T_TIMEOUT = 5000;

    logic       clock = 1'b0;
    logic       reset;
    logic       jogar;
    logic [3:0] botoes;
    logic       nivel;
    logic       memoria;
    logic [3:0] leds;
    logic       ganhou, perdeu, pronto, timeout;
    logic       db_jogadaIgualMemoria, db_enderecoIgualSequencia, db_tem_jogada, db_fimS;
    logic [6:0] display_sequencia, display_jogada, display_memoria, display_endereco, display_estado;

    int errors = 0;
    int checks = 0;

    // Game ROMs and 7-segment glyphs (active-low, bit0 = a).
    logic [3:0] rom_tab [0:1][0:15] = '{
        '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1, 4'd4},
        '{4'd8, 4'd4, 4'd2, 4'd1, 4'd1, 4'd2, 4'd4, 4'd8, 4'd2, 4'd8, 4'd1, 4'd4, 4'd4, 4'd1, 4'd8, 4'd2}
    };
    logic [6:0] seg_tab [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic       mem;
        logic       niv;
        int         err_round;
        int         err_pos;
        logic [3:0] wrong_val;
        logic       exp_ganhou;
        logic       exp_perdeu;
        logic [3:0] exp_estado;
    } scenario_t;

    scenario_t scenarios [0:3];

    jogo_desafio_memoria #(
        .T_SHOW(T_SHOW),
        .T_TIMEOUT(T_TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .jogar(jogar),
        .botoes(botoes),
        .nivel(nivel),
        .memoria(memoria),
        .leds(leds),
        .ganhou(ganhou),
        .perdeu(perdeu),
        .pronto(pronto),
        .timeout(timeout),
        .db_jogadaIgualMemoria(db_jogadaIgualMemoria),
        .db_enderecoIgualSequencia(db_enderecoIgualSequencia),
        .db_tem_jogada(db_tem_jogada),
        .db_fimS(db_fimS),
        .display_sequencia(display_sequencia),
        .display_jogada(display_jogada),
        .display_memoria(display_memoria),
        .display_endereco(display_endereco),
        .display_estado(display_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] b, input int cycles);
        botoes = b;
        repeat (cycles) @(negedge clock);
    endtask

    // Bounded wait for a state glyph; an expired budget shows up as a FAIL.
    task automatic waitEstado(input logic [3:0] code, input int budget, input string name);
        int c = 0;
        while (display_estado !== seg_tab[code] && c < budget) begin
            @(negedge clock);
            c++;
        end
        checkOutput(name, display_estado, seg_tab[code]);
    endtask

    // Start a game, then scramble nivel/memoria to prove they were latched.
    task automatic startGame(input logic m, input logic n);
        memoria = m;
        nivel   = n;
        jogar   = 1'b1;
        repeat (5) @(negedge clock);
        jogar   = 1'b0;
        memoria = ~m;
        nivel   = ~n;
    endtask

    // Game-rule model: a game of 8/16 rounds is lost exactly when the planned
    // wrong play lands inside the game and differs from the ROM item it replaces.
    function automatic void predictOutcome(input logic m, input logic n, input int err_round,
                                           input int err_pos, input logic [3:0] wrong_val,
                                           output logic g, output logic p, output logic [3:0] code);
        int rounds;
        bit lost;
        rounds = n ? 16 : 8;
        lost = (err_round >= 0) && (err_round < rounds) && (err_pos <= err_round)
               && (wrong_val != rom_tab[m][err_pos]);
        g    = !lost;
        p    = lost;
        code = lost ? 4'hE : 4'hA;
    endfunction

    task automatic playGame(input logic m, input logic n, input int err_round,
                            input int err_pos, input logic [3:0] wrong_val);
        int         last_round;
        int         hold;
        int         rel;
        logic [3:0] val;
        bit         done;
        last_round = n ? 15 : 7;
        done = 1'b0;
        startGame(m, n);
        for (int k = 0; k <= last_round && !done; k++) begin
            waitEstado(4'h2, 20, "enter mostra");
            checkOutput("show leds", leds, rom_tab[m][k]);
            checkOutput("display_sequencia", display_sequencia, seg_tab[k]);
            checkOutput("db_fimS", db_fimS, (k == last_round));
            if (k == 1) begin
                jogar = 1'b1;
                repeat (2) @(negedge clock);
                jogar = 1'b0;
            end
            waitEstado(4'h3, T_SHOW + 20, "enter espera");
            checkOutput("endereco==sequencia", db_enderecoIgualSequencia, (k == 0));
            for (int i = 0; i <= k && !done; i++) begin
                if (i > 0) begin
                    waitEstado(4'h3, 20, "back to espera");
                    checkOutput("display_jogada", display_jogada, seg_tab[rom_tab[m][i-1]]);
                    checkOutput("jogada==memoria", db_jogadaIgualMemoria,
                                (rom_tab[m][i-1] == rom_tab[m][i]));
                end
                checkOutput("display_endereco", display_endereco, seg_tab[i]);
                checkOutput("display_memoria", display_memoria, seg_tab[rom_tab[m][i]]);
                val  = (k == err_round && i == err_pos) ? wrong_val : rom_tab[m][i];
                hold = $urandom_range(2, 4);
                rel  = $urandom_range(2, 4);
                applyStimulus(val, 1);
                checkOutput("db_tem_jogada", db_tem_jogada, 1);
                checkOutput("leds echo", leds, val);
                applyStimulus(val, hold - 1);
                applyStimulus(4'b0000, rel);
                if (val != rom_tab[m][i]) done = 1'b1;
            end
        end
        if (done) waitEstado(4'hE, 20, "enter fim_errou");
        else      waitEstado(4'hA, 20, "enter fim_acertou");
    endtask

    task automatic checkEnd(input string tag, input logic g, input logic p, input logic [3:0] code);
        checkOutput({tag, " ganhou"}, ganhou, g);
        checkOutput({tag, " perdeu"}, perdeu, p);
        checkOutput({tag, " pronto"}, pronto, 1);
        checkOutput({tag, " timeout"}, timeout, 0);
        checkOutput({tag, " estado"}, display_estado, seg_tab[code]);
    endtask

    initial begin
        logic       m, n, g, p;
        logic [3:0] code, wv;
        int         er, ep, show_cnt, leds_bad, wait_cnt;

        scenarios[0] = '{1'b0, 1'b0, -1, 0, 4'b0000, 1'b1, 1'b0, 4'hA};
        scenarios[1] = '{1'b0, 1'b0,  2, 1, 4'b0100, 1'b0, 1'b1, 4'hE};
        scenarios[2] = '{1'b1, 1'b1, -1, 0, 4'b0000, 1'b1, 1'b0, 4'hA};
        scenarios[3] = '{1'b1, 1'b0,  0, 0, 4'b1001, 1'b0, 1'b1, 4'hE};

        reset = 1'b0; jogar = 1'b0; botoes = 4'b0000; nivel = 1'b0; memoria = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        checkOutput("reset estado", display_estado, seg_tab[0]);
        checkOutput("reset ganhou", ganhou, 0);
        checkOutput("reset perdeu", perdeu, 0);
        checkOutput("reset pronto", pronto, 0);
        checkOutput("reset timeout", timeout, 0);
        checkOutput("reset leds", leds, 0);
        checkOutput("reset display_sequencia", display_sequencia, seg_tab[0]);
        checkOutput("reset display_jogada", display_jogada, seg_tab[0]);
        checkOutput("reset endereco==sequencia", db_enderecoIgualSequencia, 1);
        checkOutput("reset db_fimS", db_fimS, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("idle holds", display_estado, seg_tab[0]);

        // Asynchronous reset in the middle of the show window
        startGame(1'b0, 1'b0);
        checkOutput("pre-reset mostra", display_estado, seg_tab[2]);
        #2 reset = 1'b0;
        #1;
        checkOutput("async reset estado", display_estado, seg_tab[0]);
        checkOutput("async reset leds", leds, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Table-driven whole games
        for (int s = 0; s < 4; s++) begin
            $display("[TB] scenario %0d: memoria=%0b nivel=%0b", s, scenarios[s].mem, scenarios[s].niv);
            playGame(scenarios[s].mem, scenarios[s].niv, scenarios[s].err_round,
                     scenarios[s].err_pos, scenarios[s].wrong_val);
            checkEnd("table", scenarios[s].exp_ganhou, scenarios[s].exp_perdeu, scenarios[s].exp_estado);
        end

        // Randomized games, each ending with a wrong play in an early round
        for (int r = 0; r < 4; r++) begin
            m  = 1'($urandom_range(0, 1));
            n  = 1'($urandom_range(0, 1));
            er = $urandom_range(0, 5);
            ep = $urandom_range(0, er);
            do wv = 4'($urandom_range(1, 15)); while (wv == rom_tab[m][ep]);
            $display("[TB] random game %0d: memoria=%0b nivel=%0b round=%0d pos=%0d play=%b",
                     r, m, n, er, ep, wv);
            predictOutcome(m, n, er, ep, wv, g, p, code);
            playGame(m, n, er, ep, wv);
            checkEnd("random", g, p, code);
        end

        // Restart from FIM_ERROU, then measure show window and idle behaviour
        memoria = 1'b1;
        nivel   = 1'b0;
        jogar   = 1'b1;
        @(negedge clock);
        checkOutput("restart prepara", display_estado, seg_tab[1]);
        jogar = 1'b0;
        @(negedge clock);
        checkOutput("restart mostra", display_estado, seg_tab[2]);
        checkOutput("restart ganhou", ganhou, 0);
        checkOutput("restart perdeu", perdeu, 0);
        checkOutput("restart pronto", pronto, 0);
        show_cnt = 0;
        leds_bad = 0;
        while (display_estado === seg_tab[2] && show_cnt < 2 * T_SHOW) begin
            if (leds !== rom_tab[1][0]) leds_bad++;
            show_cnt++;
            @(negedge clock);
        end
        checkOutput("show length", show_cnt, T_SHOW);
        checkOutput("show leds steady", leds_bad, 0);
        checkOutput("after show espera", display_estado, seg_tab[3]);
        wait_cnt = 0;
        while (display_estado === seg_tab[3] && wait_cnt < T_TIMEOUT + 200) begin
            wait_cnt++;
            @(negedge clock);
        end
`ifdef TIMEOUT_EN
        checkOutput("idle length", wait_cnt, T_TIMEOUT);
        checkOutput("timeout estado", display_estado, seg_tab[4'hD]);
        checkOutput("timeout flag", timeout, 1);
        checkOutput("timeout perdeu", perdeu, 1);
        checkOutput("timeout pronto", pronto, 1);
        checkOutput("timeout ganhou", ganhou, 0);
`else
        checkOutput("idle length", wait_cnt, T_TIMEOUT + 200);
        checkOutput("no timeout estado", display_estado, seg_tab[3]);
        checkOutput("no timeout flag", timeout, 0);
        checkOutput("no timeout pronto", pronto, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jogo_desafio_memoria.md
Name: jogo_desafio_memoria

Overview:
Simon-style memory game controller plus datapath for a 1 kHz board clock.
- Each round appends one item from a selectable 16-entry ROM and shows the new item on the LEDs.
- The player then repeats the whole sequence so far on four one-hot buttons.
- A wrong button loses, silence loses, and completing the last round wins.
- Top level of the game; drives LEDs, status outputs, debug flags and five 7-segment displays.

Parameters:
T_SHOW, 1000, cycles the new round's item is lit on leds (1 s).
T_TIMEOUT, 5000, cycles allowed between plays in the wait state before timeout (5 s).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous reset, active-low.
jogar  in  1  start request, level-sensitive, sampled in idle/end states.
botoes  in  4  player buttons, one-hot; 0000 = no press.
nivel  in  1  0 = 8 rounds, 1 = 16 rounds; latched at start.
memoria  in  1  selects ROM 0 or ROM 1; latched at start.
leds  out  4  shows the item during the show state; otherwise echoes botoes.
ganhou  out  1  high in the win state.
perdeu  out  1  high in the wrong-play or timeout end state.
pronto  out  1  high in any end state.
timeout  out  1  high in the timeout end state.
db_jogadaIgualMemoria  out  1  registered play == ROM[endereco].
db_enderecoIgualSequencia  out  1  endereco == sequencia.
db_tem_jogada  out  1  botoes != 0.
db_fimS  out  1  sequencia == last round (7 or 15).
display_sequencia  out  7  hex of sequencia.
display_jogada  out  7  hex of registered play.
display_memoria  out  7  hex of ROM[endereco].
display_endereco  out  7  hex of endereco.
display_estado  out  7  hex of state code.

Behaviour:
- Reset (reset=0, async): state INICIAL.
  - Counters, play register and latched nivel/memoria cleared.
  - All status outputs 0; leds 0000.
- 7-segment encoding: bit0 = a … bit6 = g, segments active-low. Hex 0-F glyphs; the "d" glyph is lower-case.
- ROM 0 (addr 0..15): 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4.
- ROM 1 (addr 0..15): 8,4,2,1,1,2,4,8,2,8,1,4,4,1,8,2.
- A play is registered on the rising edge of (botoes != 0); holding a button counts once. Play register stores botoes.
- FSM states and codes:
  - INICIAL (0): pronto=0. jogar=1 -> PREPARA.
  - PREPARA (1): clear sequencia, endereco, timers; latch nivel and memoria -> MOSTRA.
  - MOSTRA (2): leds = ROM[sequencia] for T_SHOW cycles; clear endereco and timer -> ESPERA.
  - ESPERA (3): timer increments each cycle.
    - Play edge -> REGISTRA, timer cleared.
    - Timer reaches T_TIMEOUT-1 -> FIM_TIMEOUT.
  - REGISTRA (4): load play register -> COMPARA.
  - COMPARA (5): mismatch -> FIM_ERROU; match and endereco == sequencia -> PROX_SEQ; else PROX_JOG.
  - PROX_JOG (6): endereco+1 -> ESPERA.
  - PROX_SEQ (7): db_fimS=1 -> FIM_ACERTOU; else sequencia+1 -> MOSTRA.
  - FIM_ACERTOU (A): ganhou=1, pronto=1.
  - FIM_ERROU (E): perdeu=1, pronto=1.
  - FIM_TIMEOUT (D): perdeu=1, timeout=1, pronto=1.
  - All end states: jogar=1 -> PREPARA (restart); otherwise hold.
- Counters are 4 bits and never wrap in normal play.
- Timing: each play needs ≥2 cycles of zero between presses. Any play in ESPERA is legal; presses outside ESPERA are ignored (edge tracking continues).
- Multi-hot press: registered as-is, never matches, so it loses.
- jogar high during a game is ignored.

Optional Feature:
TIMEOUT_EN
- Defined: ESPERA timer, FIM_TIMEOUT state and the timeout output are active as described.
- Undefined: no timer; ESPERA waits indefinitely; timeout tied 0; FIM_TIMEOUT unreachable.

Test Plan:
- Reset pulse -> display_estado shows 0; ganhou, perdeu, pronto, timeout = 0; leds = 0000.
- memoria=0, nivel=0, jogar 5 cycles, then each round entered 4000 cycles apart:
  - round k plays ROM0[0..k], e.g. round 3 = 0001, 0010, 0100, 1000.
  - After round 8: ganhou=1, pronto=1, display_estado shows A.
- After round 2 of the same game, press 0100 instead of 0010 -> perdeu=1, timeout=0, estado E.
- Start, wait 1000 show cycles plus 5000 idle cycles without pressing -> timeout=1, perdeu=1, estado D (TIMEOUT_EN defined). Undefined: stays in estado 3.
- memoria=1, nivel=1: 16 correct rounds from ROM 1 -> ganhou=1; db_fimS=1 only at sequencia=15.
- From FIM_ERROU, pulse jogar -> PREPARA then MOSTRA; leds = ROM[0] for 1000 cycles; status outputs clear.
